// File: rtl/nib2byte_pkg.sv
// nib2byte_pkg: shared depth and width constants for the nibble-to-byte FIFO controller.
package nib2byte_pkg;

    localparam int unsigned NIB_DEPTH  = 1024;
    localparam int unsigned BYTE_DEPTH = 512;
    localparam int unsigned NIB_AW     = 10;
    localparam int unsigned BYTE_AW    = 9;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned BYTE_W     = 8;

    // Pointer widths carry one wrap bit above the RAM address.
    localparam int unsigned WP_W = $clog2(NIB_DEPTH) + 1;
    localparam int unsigned RP_W = $clog2(BYTE_DEPTH) + 1;

endpackage

// File: rtl/nib2byte_flag_gen.sv
// nib2byte_flag_gen: registered FULL/EMPTY (and optional almost) flags from the next
// occupancy value, so flags line up with the NIB_CNT register.
// Optional feature macro: XRAM_FIFO_ALMOST_EN adds ALMOST_FULL/ALMOST_EMPTY.
module nib2byte_flag_gen
    import nib2byte_pkg::*;
`ifdef XRAM_FIFO_ALMOST_EN
#(
    parameter int unsigned AF_THRESH = 1000,
    parameter int unsigned AE_THRESH = 3
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_nxt,
`ifdef XRAM_FIFO_ALMOST_EN
    output logic             almost_full,
    output logic             almost_empty,
`endif
    output logic             full,
    output logic             empty
);

    // Full/empty registered from the occupancy about to be loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            full  <= (cnt_nxt == CNT_W'(NIB_DEPTH));
            empty <= (cnt_nxt < CNT_W'(2));
        end
    end

`ifdef XRAM_FIFO_ALMOST_EN
    // Threshold flags registered alongside full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (32'(cnt_nxt) >= AF_THRESH);
            almost_empty <= (32'(cnt_nxt) <= AE_THRESH);
        end
    end
`endif

endmodule

// File: rtl/nib2byte_fifo_ctrl.sv
// nib2byte_fifo_ctrl: pointer/occupancy/flag controller for a 1024x4 (write) /
// 512x8 (read) dual-port RAM. Storage lives in the external RAM primitive.
// Optional feature macro: XRAM_FIFO_ALMOST_EN (ALMOST_FULL/ALMOST_EMPTY, AF_THRESH/AE_THRESH).
module nib2byte_fifo_ctrl
    import nib2byte_pkg::*;
`ifdef XRAM_FIFO_ALMOST_EN
#(
    parameter int unsigned AF_THRESH = 1000,
    parameter int unsigned AE_THRESH = 3
)
`endif
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [NIB_W-1:0]   DIN,
    input  logic               RD_EN,
    output logic [BYTE_W-1:0]  DOUT,
    output logic               DOUT_VLD,
    output logic               FULL,
    output logic               EMPTY,
    output logic [CNT_W-1:0]   NIB_CNT,
    output logic               OVF,
    output logic               UDF,
`ifdef XRAM_FIFO_ALMOST_EN
    output logic               ALMOST_FULL,
    output logic               ALMOST_EMPTY,
`endif
    output logic [NIB_AW-1:0]  RAM_ADDRA,
    output logic [NIB_W-1:0]   RAM_DIA,
    output logic               RAM_ENA,
    output logic               RAM_WEA,
    output logic               RAM_RSTA,
    output logic [BYTE_AW-1:0] RAM_ADDRB,
    output logic               RAM_ENB,
    output logic               RAM_WEB,
    output logic               RAM_RSTB,
    input  logic [BYTE_W-1:0]  RAM_DOB
);

    logic [WP_W-1:0]  wp_q;
    logic [RP_W-1:0]  rp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             wr_acc_c;
    logic             rd_acc_c;

    // Acceptance qualified by the registered flags.
    assign wr_acc_c = WR_EN & ~FULL;
    assign rd_acc_c = RD_EN & ~EMPTY;

    // Next occupancy: +1 per nibble written, -2 per byte read.
    always_comb begin
        cnt_nxt_c = cnt_q;
        case ({wr_acc_c, rd_acc_c})
            2'b10:   cnt_nxt_c = cnt_q + CNT_W'(1);
            2'b01:   cnt_nxt_c = cnt_q - CNT_W'(2);
            2'b11:   cnt_nxt_c = cnt_q - CNT_W'(1);
            default: cnt_nxt_c = cnt_q;
        endcase
    end

    // Pointers, occupancy and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            DOUT_VLD <= 1'b0;
            OVF      <= 1'b0;
            UDF      <= 1'b0;
        end else begin
            if (wr_acc_c) wp_q <= wp_q + WP_W'(1);
            if (rd_acc_c) rp_q <= rp_q + RP_W'(1);
            cnt_q    <= cnt_nxt_c;
            DOUT_VLD <= rd_acc_c;
            OVF      <= WR_EN & FULL;
            UDF      <= RD_EN & EMPTY;
        end
    end

    assign NIB_CNT = cnt_q;
    assign DOUT    = RAM_DOB;

    // RAM port drive; enables only on accepted transfers so DOB holds otherwise.
    assign RAM_ADDRA = wp_q[NIB_AW-1:0];
    assign RAM_DIA   = DIN;
    assign RAM_ENA   = wr_acc_c;
    assign RAM_WEA   = wr_acc_c;
    assign RAM_RSTA  = 1'b0;
    assign RAM_ADDRB = rp_q[BYTE_AW-1:0];
    assign RAM_ENB   = rd_acc_c;
    assign RAM_WEB   = 1'b0;
    assign RAM_RSTB  = 1'b0;

    // Flag generation from the next occupancy.
    nib2byte_flag_gen
`ifdef XRAM_FIFO_ALMOST_EN
    #(
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    )
`endif
    u_flag_gen (
        .clk          (CLK),
        .rst          (RST),
        .cnt_nxt      (cnt_nxt_c),
`ifdef XRAM_FIFO_ALMOST_EN
        .almost_full  (ALMOST_FULL),
        .almost_empty (ALMOST_EMPTY),
`endif
        .full         (FULL),
        .empty        (EMPTY)
    );

    // Occupancy must always equal nibbles written minus twice the bytes read.
    a_cnt_consistent: assert property (@(posedge CLK) disable iff (RST)
        (wp_q - {rp_q, 1'b0}) == cnt_q);

endmodule

// File: tb/tb_nib2byte_fifo_ctrl.sv
// tb_nib2byte_fifo_ctrl: scoreboard bench with a behavioural 1024x4/512x8 RAM model.
// Optional feature macro: XRAM_FIFO_ALMOST_EN (bench uses AF_THRESH=8, AE_THRESH=3).
module tb_nib2byte_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic [3:0]  DIN = '0;
    logic        RD_EN = 1'b0;
    logic [7:0]  DOUT;
    logic        DOUT_VLD, FULL, EMPTY, OVF, UDF;
    logic [10:0] NIB_CNT;
    logic [9:0]  RAM_ADDRA;
    logic [3:0]  RAM_DIA;
    logic        RAM_ENA, RAM_WEA, RAM_RSTA;
    logic [8:0]  RAM_ADDRB;
    logic        RAM_ENB, RAM_WEB, RAM_RSTB;
    logic [7:0]  RAM_DOB = '0;
`ifdef XRAM_FIFO_ALMOST_EN
    localparam int unsigned AF = 8;
    localparam int unsigned AE = 3;
    logic        ALMOST_FULL, ALMOST_EMPTY;
`endif

    always #5 CLK = ~CLK;

`ifdef XRAM_FIFO_ALMOST_EN
    nib2byte_fifo_ctrl #(.AF_THRESH(AF), .AE_THRESH(AE)) u_dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
        .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .FULL(FULL), .EMPTY(EMPTY),
        .NIB_CNT(NIB_CNT), .OVF(OVF), .UDF(UDF),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA),
        .RAM_WEA(RAM_WEA), .RAM_RSTA(RAM_RSTA), .RAM_ADDRB(RAM_ADDRB),
        .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_RSTB(RAM_RSTB),
        .RAM_DOB(RAM_DOB)
    );
`else
    nib2byte_fifo_ctrl u_dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
        .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .FULL(FULL), .EMPTY(EMPTY),
        .NIB_CNT(NIB_CNT), .OVF(OVF), .UDF(UDF),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA),
        .RAM_WEA(RAM_WEA), .RAM_RSTA(RAM_RSTA), .RAM_ADDRB(RAM_ADDRB),
        .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_RSTB(RAM_RSTB),
        .RAM_DOB(RAM_DOB)
    );
`endif

    // Behavioural RAM: nibble writes on A, registered byte reads on B.
    logic [3:0] mem [1024];
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB) RAM_DOB <= {mem[{RAM_ADDRB, 1'b1}], mem[{RAM_ADDRB, 1'b0}]};
    end

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] mq [$];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every registered output against the model after an edge.
    task automatic check_state(input bit vld_e, input bit ovf_e, input bit udf_e);
        check("nib_cnt", 32'(NIB_CNT), 32'(mq.size()));
        check("empty", 32'(EMPTY), 32'(mq.size() < 2));
        check("full", 32'(FULL), 32'(mq.size() == 1024));
        check("ovf", 32'(OVF), 32'(ovf_e));
        check("udf", 32'(UDF), 32'(udf_e));
        check("dout_vld", 32'(DOUT_VLD), 32'(vld_e));
`ifdef XRAM_FIFO_ALMOST_EN
        check("almost_full", 32'(ALMOST_FULL), 32'(mq.size() >= AF));
        check("almost_empty", 32'(ALMOST_EMPTY), 32'(mq.size() <= AE));
`endif
        if (DOUT_VLD) begin
            if (exp_q.size() == 0) check("dout_unexpected", 32'(DOUT_VLD), 32'(0));
            else check("dout", 32'(DOUT), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic cycle(input logic wr, input logic [3:0] din, input logic rd);
        bit wr_ok, rd_ok, ovf_e, udf_e;
        logic [3:0] lo, hi;
        WR_EN = wr; DIN = din; RD_EN = rd;
        ovf_e = wr && (mq.size() == 1024);
        wr_ok = wr && !ovf_e;
        udf_e = rd && (mq.size() < 2);
        rd_ok = rd && !udf_e;
        if (rd_ok) begin
            lo = mq.pop_front();
            hi = mq.pop_front();
            exp_q.push_back({hi, lo});
        end
        if (wr_ok) mq.push_back(din);
        @(posedge CLK); #1;
        WR_EN = 1'b0; RD_EN = 1'b0;
        check_state(rd_ok, ovf_e, udf_e);
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        RST = 1'b1; WR_EN = wr; RD_EN = rd; DIN = 4'hF;
        mq.delete();
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
        check_state(1'b0, 1'b0, 1'b0);
        check("ram_ties", 32'({RAM_WEB, RAM_RSTA, RAM_RSTB}), 32'(0));
    endtask

    initial begin
        @(posedge CLK); #1;
        do_reset(1'b0, 1'b0);

        // Basic byte assembly.
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b1, 4'h2, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        check("byte21", 32'(DOUT), 32'h21);

        // Underflow with one odd nibble stored, then its partner arrives.
        cycle(1'b1, 4'h5, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b1, 4'h6, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);

        // Fill to full, then overflow attempt.
        for (int i = 0; i < 1024; i++) cycle(1'b1, 4'(i), 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b1);

        // Sustained simultaneous write+read across the read-address wrap.
        for (int i = 0; i < 600; i++) cycle(1'b1, 4'(i * 7), 1'b1);

        // Random mix.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));

        // Drain, then one read too many.
        while (mq.size() >= 2) cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);

        // Reset mid-stream while a read is requested.
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 3), 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        // Threshold region: 8 nibbles in, 3 bytes out.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 8), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        check("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
